// File: rtl/hash_session_arbiter.sv
// hash_session_arbiter: grants one client at a time a session on a shared byte-serial hash core.
// Optional macro HASH_ARB_PRIO_EN gives client 0 fixed priority; clients 1..N_REQ-1 stay round-robin.
module hash_session_arbiter #(
  parameter int N_REQ    = 4,
  parameter int DIGEST_W = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [N_REQ-1:0]      req_i,
  input  logic [8*N_REQ-1:0]    byte_i,
  input  logic [N_REQ-1:0]      byte_valid_i,
  input  logic [N_REQ-1:0]      last_i,
  output logic [N_REQ-1:0]      byte_ready_o,
  output logic [N_REQ-1:0]      grant_o,
  output logic [N_REQ-1:0]      done_o,
  output logic [DIGEST_W-1:0]   digest_o,
  output logic                  busy_o,
  output logic                  core_start_msg,
  output logic                  core_msg_done,
  output logic                  core_valid_in,
  output logic [7:0]            core_byte,
  input  logic                  core_load_byte,
  input  logic                  core_digest_ready,
  input  logic [DIGEST_W-1:0]   core_digest
);

  localparam int IW = $clog2(N_REQ);

  typedef enum logic [1:0] {IDLE, START, STREAM, WAIT} state_e;

  state_e              state_q;
  logic [IW-1:0]       owner_q;
  logic [IW-1:0]       rr_q;
  logic [IW-1:0]       win_d;
  logic [N_REQ-1:0]    grant_q;
  logic [N_REQ-1:0]    done_q;
  logic [DIGEST_W-1:0] digest_q;
  logic                found;
  int                  idx;

  logic                ownValid;
  logic                ownLast;
  logic [7:0]          ownByte;
  logic                empty;
  logic                xfer;

  always_comb begin
    ownValid = 1'b0;
    ownLast  = 1'b0;
    ownByte  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (owner_q == IW'(i)) begin
        ownValid = byte_valid_i[i];
        ownLast  = last_i[i];
        ownByte  = byte_i[8*i +: 8];
      end
    end
  end

`ifdef HASH_ARB_PRIO_EN
  logic last0_q;
  int   rrBase;

  // Client 0 yields once after its own session when others wait, so it cannot starve them.
  always_comb begin
    win_d  = rr_q;
    found  = 1'b0;
    idx    = 0;
    rrBase = (rr_q == '0) ? N_REQ - 1 : int'(rr_q);
    if (req_i[0] && !(last0_q && (|req_i[N_REQ-1:1]))) begin
      win_d = '0;
      found = 1'b1;
    end
    for (int k = 1; k < N_REQ; k++) begin
      idx = (rrBase - 1 + k) % (N_REQ - 1) + 1;
      if (!found && req_i[idx]) begin
        win_d = IW'(idx);
        found = 1'b1;
      end
    end
  end
`else
  always_comb begin
    win_d = rr_q;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(rr_q) + k) % N_REQ;
      if (!found && req_i[idx]) begin
        win_d = IW'(idx);
        found = 1'b1;
      end
    end
  end
`endif

  assign empty = ownLast & ~ownValid;
  assign xfer  = (state_q == STREAM) & ownValid & core_load_byte;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_q     <= IW'(N_REQ - 1);
      grant_q  <= '0;
      done_q   <= '0;
      digest_q <= '0;
`ifdef HASH_ARB_PRIO_EN
      last0_q  <= 1'b0;
`endif
    end else begin
      done_q <= '0;
      case (state_q)
        IDLE: begin
          if (|req_i) begin
            owner_q <= win_d;
            grant_q <= {{(N_REQ-1){1'b0}}, 1'b1} << win_d;
            state_q <= START;
`ifdef HASH_ARB_PRIO_EN
            if (win_d != '0) rr_q <= win_d;
            last0_q <= (win_d == '0);
`else
            rr_q    <= win_d;
`endif
          end
        end
        START:   state_q <= empty ? WAIT : STREAM;
        STREAM:  if (xfer && ownLast) state_q <= WAIT;
        WAIT: begin
          if (core_digest_ready) begin
            digest_q <= core_digest;
            done_q   <= grant_q;
            grant_q  <= '0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant_o        = grant_q;
  assign done_o         = done_q;
  assign digest_o       = digest_q;
  assign busy_o         = (state_q != IDLE);
  assign core_start_msg = (state_q == START);
  assign core_msg_done  = ((state_q == START) & empty) | (xfer & ownLast);
  assign core_valid_in  = (state_q == STREAM) & ownValid;
  assign core_byte      = (state_q == STREAM) ? ownByte : 8'h00;
  assign byte_ready_o   = ((state_q == STREAM) && core_load_byte) ? grant_q : '0;

endmodule

// File: tb/tb_hash_session_arbiter.sv
// tb_hash_session_arbiter: directed sessions against a session-level model of the arbiter.
// Also honours HASH_ARB_PRIO_EN when the design is built with it.
module tb_hash_session_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;

  logic          clk     = 1'b0;
  logic          reset_n = 1'b0;
  logic [N-1:0]  req_i   = '0;
  logic [8*N-1:0] byte_i;
  logic [N-1:0]  byte_valid_i;
  logic [N-1:0]  last_i;
  logic [N-1:0]  byte_ready_o;
  logic [N-1:0]  grant_o;
  logic [N-1:0]  done_o;
  logic [DW-1:0] digest_o;
  logic          busy_o;
  logic          core_start_msg;
  logic          core_msg_done;
  logic          core_valid_in;
  logic [7:0]    core_byte;
  logic          core_load_byte;
  logic          core_digest_ready;
  logic [DW-1:0] core_digest;

  logic          coreAccept = 1'b1;
  logic          respReady  = 1'b0;
  logic          spurReady  = 1'b0;
  logic [DW-1:0] digestBase = '0;
  int            len  [N];
  logic [7:0]    base [N];
  logic [N-1:0]  stall = '0;
  int            idx  [N];

  int            nChecks = 0;
  int            nFail   = 0;
  int            startCount = 0;
  int            bothCount  = 0;
  int            validCount = 0;
  int            rdyCount [N];
  logic [7:0]    lastDoneByte = 8'h00;
  int            grantLog [$];
  logic [N-1:0]  prevGrant = '0;
  logic [N-1:0]  rdySnap = '0;
  logic [N-1:0]  doneSnap = '0;
  logic          msgDoneSnap = 1'b0;

  int            mPhase = 0;
  int            mOwner = 0;
  int            mPtr   = N - 1;
  logic [DW-1:0] mDigest = '0;
  logic [N-1:0]  mDone = '0;
  logic          mLast0 = 1'b0;

  logic [N-1:0]  eGrant, eReady;
  logic          eStart, eMsgDone, eValid, eEmpty, eLoad;
  logic [7:0]    eByte;

  always #5 clk = ~clk;

  assign core_load_byte    = core_valid_in & coreAccept;
  assign core_digest_ready = respReady | spurReady;
  assign core_digest       = spurReady ? 32'hBAD0BAD0 : digestBase;

  hash_session_arbiter #(.N_REQ(N), .DIGEST_W(DW)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .req_i             (req_i),
    .byte_i            (byte_i),
    .byte_valid_i      (byte_valid_i),
    .last_i            (last_i),
    .byte_ready_o      (byte_ready_o),
    .grant_o           (grant_o),
    .done_o            (done_o),
    .digest_o          (digest_o),
    .busy_o            (busy_o),
    .core_start_msg    (core_start_msg),
    .core_msg_done     (core_msg_done),
    .core_valid_in     (core_valid_in),
    .core_byte         (core_byte),
    .core_load_byte    (core_load_byte),
    .core_digest_ready (core_digest_ready),
    .core_digest       (core_digest)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Session arbitration rule: next requester after the pointer, wrapping.
  function automatic int pickNext(input int ptr, input logic [N-1:0] r, input logic last0);
    int c;
`ifdef HASH_ARB_PRIO_EN
    if (r[0] && !(last0 && (r[N-1:1] != '0))) return 0;
    for (int k = 1; k < N; k++) begin
      c = (ptr - 1 + k) % (N - 1) + 1;
      if (r[c]) return c;
    end
`else
    if (last0) c = 0;
    for (int k = 1; k <= N; k++) begin
      c = (ptr + k) % N;
      if (r[c]) return c;
    end
`endif
    return ptr;
  endfunction

  function automatic int logAt(input int i);
    if (i < grantLog.size()) return grantLog[i];
    return -1;
  endfunction

  // Model: session phase 0 idle, 1 start, 2 streaming, 3 awaiting digest.
  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      mPhase = 0; mOwner = 0; mPtr = N - 1; mDigest = '0; mDone = '0; mLast0 = 1'b0;
    end else begin
      mDone = '0;
      case (mPhase)
        0: if (req_i != '0) begin
          mOwner = pickNext(mPtr, req_i, mLast0);
`ifdef HASH_ARB_PRIO_EN
          if (mOwner != 0) mPtr = mOwner;
          mLast0 = (mOwner == 0);
`else
          mPtr = mOwner;
`endif
          mPhase = 1;
        end
        1: mPhase = (last_i[mOwner] && !byte_valid_i[mOwner]) ? 3 : 2;
        2: if (byte_valid_i[mOwner] && coreAccept && last_i[mOwner]) mPhase = 3;
        3: if (core_digest_ready) begin
          mDigest = core_digest;
          mDone[mOwner] = 1'b1;
          mPhase = 0;
        end
        default: mPhase = 0;
      endcase
    end
  end

  initial forever begin
    @(negedge clk);
    eGrant = '0;
    if (mPhase != 0) eGrant[mOwner] = 1'b1;
    eEmpty   = last_i[mOwner] & ~byte_valid_i[mOwner];
    eStart   = (mPhase == 1);
    eValid   = (mPhase == 2) & byte_valid_i[mOwner];
    eLoad    = eValid & coreAccept;
    eMsgDone = (eStart & eEmpty) | (eLoad & last_i[mOwner]);
    eByte    = (mPhase == 2) ? byte_i[8*mOwner +: 8] : 8'h00;
    eReady   = '0;
    eReady[mOwner] = eLoad;
    checkOutput("grant_o", grant_o, eGrant);
    checkOutput("busy_o", busy_o, mPhase != 0);
    checkOutput("core_start_msg", core_start_msg, eStart);
    checkOutput("core_msg_done", core_msg_done, eMsgDone);
    checkOutput("core_valid_in", core_valid_in, eValid);
    checkOutput("core_byte", core_byte, eByte);
    checkOutput("byte_ready_o", byte_ready_o, eReady);
    checkOutput("done_o", done_o, mDone);
    checkOutput("digest_o", digest_o, mDigest);
    if (core_start_msg) startCount++;
    if (core_start_msg && core_msg_done) bothCount++;
    if (core_valid_in) validCount++;
    if (core_msg_done && core_valid_in) lastDoneByte = core_byte;
    for (int c = 0; c < N; c++) if (byte_ready_o[c] && byte_valid_i[c]) rdyCount[c]++;
    if (grant_o != prevGrant && grant_o != '0)
      for (int c = 0; c < N; c++) if (grant_o[c]) grantLog.push_back(c);
    prevGrant   = grant_o;
    rdySnap     = byte_ready_o & byte_valid_i;
    doneSnap    = done_o;
    msgDoneSnap = core_msg_done;
  end

  // Client byte sources: message of len[c] bytes starting at base[c]; len 0 is an empty message.
  initial begin
    byte_valid_i = '0; last_i = '0; byte_i = '0;
    for (int c = 0; c < N; c++) idx[c] = 0;
    forever begin
      @(posedge clk); #2;
      for (int c = 0; c < N; c++) begin
        if (!reset_n) idx[c] = 0;
        else begin
          if (rdySnap[c]) idx[c]++;
          if (doneSnap[c]) idx[c] = 0;
        end
        if (len[c] == 0) begin
          byte_valid_i[c] = 1'b0; last_i[c] = 1'b1; byte_i[8*c +: 8] = 8'h00;
        end else if (idx[c] < len[c] && !stall[c]) begin
          byte_valid_i[c] = 1'b1;
          last_i[c] = (idx[c] == len[c] - 1);
          byte_i[8*c +: 8] = base[c] + 8'(idx[c]);
        end else begin
          byte_valid_i[c] = 1'b0; last_i[c] = 1'b0;
        end
      end
    end
  end

  // Hash core stand-in: digest-ready pulse two cycles after end of message.
  initial forever begin
    @(posedge clk);
    if (msgDoneSnap && reset_n) begin
      repeat (2) @(posedge clk);
      #1 respReady = 1'b1;
      @(posedge clk);
      #1 respReady = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [N-1:0] req);
    req_i = req;
    tick(1);
    req_i = '0;
  endtask

  task automatic waitDone(input int maxCyc, output logic [N-1:0] seen);
    seen = '0;
    for (int i = 0; i < maxCyc; i++) begin
      @(negedge clk);
      if (done_o != '0) begin
        seen = done_o;
        break;
      end
    end
  endtask

  task automatic waitGrants(input int target, input int maxCyc);
    for (int i = 0; i < maxCyc; i++) begin
      @(negedge clk);
      if (grantLog.size() >= target) break;
    end
    checkOutput("grant count", grantLog.size() >= target, 1'b1);
  endtask

  task automatic waitIdle(input int maxCyc);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < maxCyc; i++) begin
      @(negedge clk);
      if (!busy_o) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput("idle reached", ok, 1'b1);
  endtask

  initial begin
    logic [N-1:0] seen;
    int s0, b0, v0, r0, r1, r3, g0;
    int exp3 [5];
    int exp6 [6];
`ifdef HASH_ARB_PRIO_EN
    exp3 = '{0, 1, 0, 2, 0};
    exp6 = '{0, 1, 0, 3, 0, 1};
`else
    exp3 = '{0, 1, 2, 3, 0};
    exp6 = '{0, 1, 3, 0, 1, 3};
`endif
    for (int c = 0; c < N; c++) begin
      len[c] = 0;
      base[c] = 8'h00;
    end
    $display("[TB] start");
    tick(2);
    checkOutput("reset grant", grant_o, 4'b0000);
    checkOutput("reset busy", busy_o, 1'b0);
    checkOutput("reset digest", digest_o, 32'h0);
    reset_n = 1'b1;
    tick(1);

    // Single two-byte session from client 1.
    digestBase = 32'hDEADBEEF;
    base[1] = 8'h61; len[1] = 2;
    s0 = startCount; r1 = rdyCount[1];
    tick(1);
    req_i = 4'b0010;
    @(negedge clk);
    checkOutput("t2 grant before sample", grant_o, 4'b0000);
    @(negedge clk);
    checkOutput("t2 grant", grant_o, 4'b0010);
    checkOutput("t2 start", core_start_msg, 1'b1);
    tick(1);
    req_i = '0;
    waitDone(60, seen);
    checkOutput("t2 done", seen, 4'b0010);
    checkOutput("t2 digest", digest_o, 32'hDEADBEEF);
    checkOutput("t2 start pulses", startCount - s0, 1);
    checkOutput("t2 ready pulses", rdyCount[1] - r1, 2);
    checkOutput("t2 last byte", lastDoneByte, 8'h62);
    tick(1);
    len[1] = 0;

    // Empty message from client 2.
    digestBase = 32'h12345678;
    s0 = startCount; b0 = bothCount; v0 = validCount;
    applyStimulus(4'b0100);
    waitDone(60, seen);
    checkOutput("t4 done", seen, 4'b0100);
    checkOutput("t4 start with msg_done", bothCount - b0, 1);
    checkOutput("t4 no bytes", validCount - v0, 0);
    checkOutput("t4 digest", digest_o, 32'h12345678);

    // Digest-ready while idle must be ignored.
    tick(2);
    spurReady = 1'b1;
    tick(1);
    spurReady = 1'b0;
    tick(1);
    @(negedge clk);
    checkOutput("spurious digest", digest_o, 32'h12345678);
    checkOutput("spurious done", done_o, 4'b0000);
    tick(1);

    // Owner stalls while a non-owner keeps offering bytes.
    digestBase = 32'hCAFEF00D;
    base[3] = 8'hA0; len[3] = 3;
    base[0] = 8'h10; len[0] = 2;
    r0 = rdyCount[0]; r3 = rdyCount[3];
    applyStimulus(4'b1000);
    stall[3] = 1'b1;
    repeat (5) begin
      @(negedge clk);
      checkOutput("t5 stall valid", core_valid_in, 1'b0);
      checkOutput("t5 non-owner ready", byte_ready_o[0], 1'b0);
    end
    tick(1);
    stall[3] = 1'b0;
    coreAccept = 1'b0;
    tick(2);
    coreAccept = 1'b1;
    waitDone(60, seen);
    checkOutput("t5 done", seen, 4'b1000);
    checkOutput("t5 owner bytes", rdyCount[3] - r3, 3);
    checkOutput("t5 non-owner bytes", rdyCount[0] - r0, 0);
    checkOutput("t5 digest", digest_o, 32'hCAFEF00D);
    tick(1);

    // All clients request with one-byte messages.
    digestBase = 32'h0BADF00D;
    for (int c = 0; c < N; c++) begin
      len[c] = 1;
      base[c] = 8'(48 + 16 * c);
    end
    g0 = grantLog.size();
    req_i = 4'b1111;
    waitGrants(g0 + 5, 400);
    tick(1);
    req_i = '0;
    waitIdle(100);
    for (int i = 0; i < 5; i++) checkOutput($sformatf("t3 grant %0d", i), logAt(g0 + i), exp3[i]);
    tick(1);

    // Reset in the middle of a stream.
    for (int c = 0; c < N; c++) len[c] = 0;
    base[2] = 8'h70; len[2] = 3;
    applyStimulus(4'b0100);
    tick(1);
    checkOutput("t1 busy before reset", busy_o, 1'b1);
    reset_n = 1'b0;
    #1;
    checkOutput("t1 grant", grant_o, 4'b0000);
    checkOutput("t1 busy", busy_o, 1'b0);
    checkOutput("t1 start", core_start_msg, 1'b0);
    checkOutput("t1 msg_done", core_msg_done, 1'b0);
    checkOutput("t1 valid", core_valid_in, 1'b0);
    checkOutput("t1 byte", core_byte, 8'h00);
    checkOutput("t1 digest", digest_o, 32'h0);
    tick(2);
    checkOutput("t1 grant held", grant_o, 4'b0000);
    reset_n = 1'b1;
    len[2] = 0;
    tick(1);

    // Clients 0, 1 and 3 requesting from a fresh pointer.
    len[0] = 1; len[1] = 1; len[3] = 1;
    g0 = grantLog.size();
    req_i = 4'b1011;
    waitGrants(g0 + 6, 400);
    tick(1);
    req_i = '0;
    waitIdle(100);
    for (int i = 0; i < 6; i++) checkOutput($sformatf("t6 grant %0d", i), logAt(g0 + i), exp6[i]);

    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
